// File: rtl/neuron_mac_engine.sv
`default_nettype none
// ============================================================================
// neuron_mac_engine : per-layer MAC datapath (bias + sum x*w, shift, ReLU, sat)
// Revision 1.0 - initial release
// ============================================================================
module neuron_mac_engine #(
   parameter int DW    = 8,
   parameter int ACC_W = 24,
   parameter int FRAC  = 6,
   parameter int N_IN  = 16,
   parameter int N_H1  = 8,
   parameter int N_H2  = 8,
   parameter int N_OUT = 4,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_neuron,
   input  logic [1:0]       state,
   input  logic             hidden,
   output logic [7:0]       x_addr,
   input  logic [DW-1:0]    x_data,
   output logic [AW-1:0]    w_addr,
   input  logic [DW-1:0]    w_data,
   output logic [7:0]       b_addr,
   input  logic [ACC_W-1:0] b_data,
   output logic             busy,
   output logic             y_valid,
   output logic [3:0]       y_idx,
   output logic [DW-1:0]    y_data,
   output logic             calculation_done
);

   localparam int CW   = 8;
   localparam int H1W  = $clog2(N_H1);
   localparam int H2W  = $clog2(N_H2);
   localparam int C_WB1 = N_IN * N_H1;
   localparam int C_WB2 = C_WB1 + N_H1 * N_H2;
   localparam logic signed [ACC_W-1:0] C_YMAX = ACC_W'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] C_YMIN = ~C_YMAX;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } fsm_t;

   fsm_t fsm_q, fsm_d;

   logic [1:0]              layer_q;
   logic                    hidden_q;
   logic [CW-1:0]           i_q, j_q;
   logic [CW-1:0]           n_in, n_out, next_i;
   logic                    last_i, last_op, accept;
   logic [7:0]              x_addr_q, b_addr_q;
   logic [AW-1:0]           w_addr_q;

   logic                    s1_valid_q, s1_first_q, s1_last_q;
   logic [3:0]              s1_j_q;
   logic signed [DW-1:0]    h_rd_q;

   logic signed [DW-1:0]    h1_q [N_H1];
   logic signed [DW-1:0]    h2_q [N_H2];
   logic signed [ACC_W-1:0] acc_q;
   logic                    y_valid_q, done_q;
   logic [3:0]              y_idx_q;
   logic [DW-1:0]           y_data_q;

   logic signed [DW-1:0]     operand;
   logic signed [2*DW-1:0]   prod;
   logic signed [ACC_W-1:0]  prod_ext, sum, shifted, act_full;
   logic [DW-1:0]            act;

   function automatic logic [AW-1:0] wbase_f(input logic [1:0] l);
      case (l)
         2'd1:    wbase_f = AW'(C_WB1);
         2'd2:    wbase_f = AW'(C_WB2);
         default: wbase_f = '0;
      endcase
   endfunction

   function automatic logic [7:0] bbase_f(input logic [1:0] l);
      case (l)
         2'd1:    bbase_f = 8'(N_H1);
         2'd2:    bbase_f = 8'(N_H1 + N_H2);
         default: bbase_f = '0;
      endcase
   endfunction

   always_comb begin
      n_in  = CW'(N_IN);
      n_out = CW'(N_H1);
      case (layer_q)
         2'd1: begin
            n_in  = CW'(N_H1);
            n_out = CW'(N_H2);
         end
         2'd2: begin
            n_in  = CW'(N_H2);
            n_out = CW'(N_OUT);
         end
         default: ;
      endcase
      last_i  = (i_q == n_in - CW'(1));
      last_op = last_i && (j_q == n_out - CW'(1));
      next_i  = last_i ? '0 : i_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_q <= S_IDLE;
      else     fsm_q <= fsm_d;
   end

   // DONE deliberately ignores start_neuron so the held request cannot retrigger
   always_comb begin
      fsm_d  = fsm_q;
      accept = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (start_neuron && state != 2'b11) begin
               fsm_d  = S_RUN;
               accept = 1'b1;
            end
         end
         S_RUN:   if (last_op) fsm_d = S_DRAIN;
         S_DRAIN: fsm_d = S_DONE;
         S_DONE:  fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   // Operand sequencer: addresses for (j,i) are registered, metadata follows one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer_q    <= '0;
         hidden_q   <= 1'b0;
         i_q        <= '0;
         j_q        <= '0;
         x_addr_q   <= '0;
         w_addr_q   <= '0;
         b_addr_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_j_q     <= '0;
         h_rd_q     <= '0;
      end else begin
         s1_valid_q <= (fsm_q == S_RUN);
         if (accept) begin
            layer_q  <= state;
            hidden_q <= hidden;
            i_q      <= '0;
            j_q      <= '0;
            x_addr_q <= '0;
            w_addr_q <= wbase_f(state);
            b_addr_q <= bbase_f(state);
         end else if (fsm_q == S_RUN) begin
            s1_first_q <= (i_q == '0);
            s1_last_q  <= last_i;
            s1_j_q     <= j_q[3:0];
            h_rd_q     <= (layer_q == 2'd1) ? h1_q[i_q[H1W-1:0]] : h2_q[i_q[H2W-1:0]];
            if (!last_op) begin
               i_q      <= next_i;
               w_addr_q <= w_addr_q + AW'(1);
               x_addr_q <= (layer_q == 2'd0) ? next_i : '0;
               if (last_i) begin
                  j_q      <= j_q + CW'(1);
                  b_addr_q <= b_addr_q + 8'd1;
               end
            end
         end
      end
   end

   always_comb begin
      operand  = (layer_q == 2'd0) ? x_data : h_rd_q;
      prod     = $signed(w_data) * operand;
      prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
      sum      = (s1_first_q ? $signed(b_data) : acc_q) + prod_ext;
      shifted  = sum >>> FRAC;
      act_full = (hidden_q && shifted[ACC_W-1]) ? '0 : shifted;
      if (act_full > C_YMAX)      act = C_YMAX[DW-1:0];
      else if (act_full < C_YMIN) act = C_YMIN[DW-1:0];
      else                        act = act_full[DW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
         y_idx_q   <= '0;
         y_data_q  <= '0;
         for (int k = 0; k < N_H1; k++) h1_q[k] <= '0;
         for (int k = 0; k < N_H2; k++) h2_q[k] <= '0;
      end else begin
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
         if (s1_valid_q) begin
            acc_q <= sum;
            if (s1_last_q) begin
               y_valid_q <= 1'b1;
               y_idx_q   <= s1_j_q;
               y_data_q  <= act;
               done_q    <= (fsm_q == S_DRAIN);
               if (layer_q == 2'd0)      h1_q[s1_j_q[H1W-1:0]] <= act;
               else if (layer_q == 2'd1) h2_q[s1_j_q[H2W-1:0]] <= act;
            end
         end
      end
   end

   assign busy             = (fsm_q != S_IDLE);
   assign x_addr           = x_addr_q;
   assign w_addr           = w_addr_q;
   assign b_addr           = b_addr_q;
   assign y_valid          = y_valid_q;
   assign y_idx            = y_idx_q;
   assign y_data           = y_data_q;
   assign calculation_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_engine.sv
`default_nettype none
// ============================================================================
// tb_neuron_mac_engine : randomized bench against an arithmetic layer model
// Revision 1.0 - initial release
// ============================================================================
module tb_neuron_mac_engine;
   localparam int DW = 8, ACC_W = 24, FRAC = 6;
   localparam int N_IN = 16, N_H1 = 8, N_H2 = 8, N_OUT = 4, AW = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_neuron;
   logic [1:0]       state;
   logic             hidden;
   logic [7:0]       x_addr;
   logic [DW-1:0]    x_data;
   logic [AW-1:0]    w_addr;
   logic [DW-1:0]    w_data;
   logic [7:0]       b_addr;
   logic [ACC_W-1:0] b_data;
   logic             busy, y_valid, calculation_done;
   logic [3:0]       y_idx;
   logic [DW-1:0]    y_data;

   logic signed [7:0]  x_mem [256];
   logic signed [7:0]  w_mem [1024];
   logic signed [23:0] b_mem [256];
   int m_h1 [N_H1];
   int m_h2 [N_H2];

   int total = 0, bad = 0, cyc = 0;

   neuron_mac_engine #(.DW(DW), .ACC_W(ACC_W), .FRAC(FRAC), .N_IN(N_IN), .N_H1(N_H1),
                       .N_H2(N_H2), .N_OUT(N_OUT), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start_neuron(start_neuron), .state(state), .hidden(hidden),
      .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data), .busy(busy), .y_valid(y_valid), .y_idx(y_idx),
      .y_data(y_data), .calculation_done(calculation_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      x_data <= x_mem[x_addr];
      w_data <= w_mem[w_addr];
      b_data <= b_mem[b_addr];
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int nin_of(int lay);
      return (lay == 0) ? N_IN : (lay == 1) ? N_H1 : N_H2;
   endfunction
   function automatic int nout_of(int lay);
      return (lay == 0) ? N_H1 : (lay == 1) ? N_H2 : N_OUT;
   endfunction
   function automatic int wb_of(int lay);
      return (lay == 0) ? 0 : (lay == 1) ? N_IN * N_H1 : N_IN * N_H1 + N_H1 * N_H2;
   endfunction
   function automatic int bb_of(int lay);
      return (lay == 0) ? 0 : (lay == 1) ? N_H1 : N_H1 + N_H2;
   endfunction

   function automatic int ref_neuron(int lay, int j, bit h);
      longint acc;
      logic signed [23:0] a24;
      int s, xv, wv, nin;
      nin = nin_of(lay);
      acc = b_mem[bb_of(lay) + j];
      for (int i = 0; i < nin; i++) begin
         xv = (lay == 0) ? int'(x_mem[i]) : (lay == 1) ? m_h1[i] : m_h2[i];
         wv = w_mem[wb_of(lay) + j * nin + i];
         acc += xv * wv;
      end
      a24 = acc[23:0];
      s = int'(a24) >>> FRAC;
      if (h && s < 0) s = 0;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic fill_rand();
      int r;
      for (int k = 0; k < 256; k++) x_mem[k] = 8'($urandom_range(0, 63) - 32);
      for (int k = 0; k < 1024; k++) w_mem[k] = 8'($urandom_range(0, 63) - 32);
      for (int k = 0; k < 256; k++) begin
         r = $urandom_range(0, 4095) - 2048;
         b_mem[k] = r[23:0];
      end
   endtask

   task automatic fill_const(input int xv, input int wv, input int bv);
      for (int k = 0; k < 256; k++) x_mem[k] = xv[7:0];
      for (int k = 0; k < 1024; k++) w_mem[k] = wv[7:0];
      for (int k = 0; k < 256; k++) b_mem[k] = bv[23:0];
   endtask

   // Called at a negedge; returns at a negedge with the DUT back in IDLE.
   task automatic run_layer(input int lay, input bit h, input bit chain);
      int exp_y [16];
      int nin, nout, e0, nv;
      bit seen, got_done;
      nin  = nin_of(lay);
      nout = nout_of(lay);
      for (int j = 0; j < nout; j++) exp_y[j] = ref_neuron(lay, j, h);
      state = lay[1:0];
      hidden = h;
      start_neuron = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("start_accepted", seen, 1);
      e0 = cyc;
      nv = 0;
      got_done = 1'b0;
      for (int t = 0; t < nin * nout + 10 && !got_done && seen; t++) begin
         if (y_valid && nv < 16) begin
            chk("y_idx", y_idx, nv);
            chk("y_data", $signed(y_data), exp_y[nv]);
            chk("y_time", cyc - e0, (nv + 1) * nin + 1);
            nv++;
         end
         if (calculation_done) begin
            got_done = 1'b1;
            chk("done_time", cyc - e0, nin * nout + 1);
         end
         if (!got_done) @(negedge clk);
      end
      chk("done_seen", got_done, 1);
      chk("y_count", nv, nout);
      @(negedge clk);
      chk("done_width", calculation_done, 0);
      chk("idle_after_done", busy, 0);
      if (!chain) start_neuron = 1'b0;
      if (lay == 0) for (int j = 0; j < N_H1; j++) m_h1[j] = exp_y[j];
      if (lay == 1) for (int j = 0; j < N_H2; j++) m_h2[j] = exp_y[j];
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk(tag, {busy, y_valid, calculation_done, y_idx, y_data, x_addr, w_addr, b_addr}, 0);
   endtask

   task automatic clear_model();
      for (int j = 0; j < N_H1; j++) m_h1[j] = 0;
      for (int j = 0; j < N_H2; j++) m_h2[j] = 0;
   endtask

   initial begin
      int quiet;
      fill_rand();
      clear_model();
      rst = 1'b1;
      start_neuron = 1'b0;
      state = 2'b00;
      hidden = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("in_reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("after_reset");

      // Layer 2 straight after reset: h1 must read back as zero
      run_layer(1, 1'b0, 1'b0);

      // Reset in the middle of layer 1
      state = 2'b00;
      hidden = 1'b1;
      start_neuron = 1'b1;
      repeat (20) @(negedge clk);
      chk("busy_before_abort", busy, 1);
      rst = 1'b1;
      start_neuron = 1'b0;
      clear_model();
      @(negedge clk);
      chk_reset_outputs("mid_run_reset");
      rst = 1'b0;
      quiet = 0;
      for (int t = 0; t < 150; t++) begin
         @(negedge clk);
         if (busy || calculation_done || y_valid) quiet++;
      end
      chk("no_done_after_abort", quiet, 0);

      // Fresh start after reset, then layer 2 uses fresh h1
      run_layer(0, 1'b1, 1'b0);
      run_layer(1, 1'b1, 1'b0);

      fill_const(16, 16, 0);
      run_layer(0, 1'b1, 1'b0);
      fill_const(127, 127, 0);
      run_layer(0, 1'b1, 1'b0);
      fill_const(127, 127, -300000);
      run_layer(0, 1'b1, 1'b0);
      fill_const(127, 127, 8388607);
      run_layer(0, 1'b0, 1'b0);
      fill_const(5, 0, -20000);
      run_layer(2, 1'b0, 1'b0);

      // Controller handshake: start held across all three layers
      for (int r = 0; r < 2; r++) begin
         fill_rand();
         run_layer(0, 1'b1, 1'b1);
         run_layer(1, 1'b1, 1'b1);
         run_layer(2, 1'b0, 1'b0);
         quiet = 0;
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (busy || calculation_done || y_valid) quiet++;
         end
         chk("no_retrigger", quiet, 0);
      end

      // Reserved layer select
      state = 2'b11;
      start_neuron = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("reserved_idle", {busy, y_valid, calculation_done}, 0);
      end
      start_neuron = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/neuron_mac_engine.md
# neuron_mac_engine

Layer compute datapath driven by the network controller. On `start_neuron`, it computes every neuron of the selected layer (bias + Σ x·w, shift, optional ReLU, saturate) using synchronous weight/bias/input memories. Hidden-layer results are stored internally as inputs to the next layer, and each result is streamed out. It answers with a one-cycle `calculation_done`, which the controller uses to step HIDDEN_LAYER_1 → HIDDEN_LAYER_2 → CALCULATION.

## Interface
- `DW`, 8: signed width of activations, weights and results
- `ACC_W`, 24: signed accumulator / bias width
- `FRAC`, 6: arithmetic right shift applied to the final sum
- `N_IN`, 16: features per sample (layer-1 fan-in)
- `N_H1`, 8: layer-1 neurons (layer-2 fan-in)
- `N_H2`, 8: layer-2 neurons (output-layer fan-in)
- `N_OUT`, 4: output neurons
- `AW`, 10: weight address width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `start_neuron`  in  1  layer request, level, held by controller
- `state`  in  2  layer select: 00 layer 1, 01 layer 2, 10 output, 11 reserved
- `hidden`  in  1  1 = apply ReLU
- `x_addr`  out  8  sample-buffer address (layer 1 only)
- `x_data`  in  DW  sample value; valid 1 cycle after `x_addr`
- `w_addr`  out  AW  weight ROM address
- `w_data`  in  DW  weight; valid 1 cycle after `w_addr`
- `b_addr`  out  8  bias ROM address
- `b_data`  in  ACC_W  bias; valid 1 cycle after `b_addr`
- `busy`  out  1  high in RUN/DRAIN/DONE
- `y_valid`  out  1  one-cycle pulse per finished neuron
- `y_idx`  out  4  neuron index of `y_data`
- `y_data`  out  DW  activated, saturated result
- `calculation_done`  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN:
  - Trigger: edge with `start_neuron`=1 and `state`≠11.
  - Latch the layer and `hidden`; clear neuron counter j and input counter i.
  - `state`=11: stay in IDLE, no outputs.
- RUN:
  - Each cycle presents the operand addresses for (j,i), then advances i.
  - When i=n_in−1: i wraps to 0 and j increments.
  - RUN → DRAIN after presenting (n_out−1, n_in−1).
- DRAIN: one cycle, consumes the last operand. DRAIN → DONE.
- DONE: one cycle, then → IDLE. `start_neuron` is ignored in DONE, so the held request of the finished layer never retriggers.
- Per-layer sizes:
  - Layer 1: n_in=N_IN, n_out=N_H1
  - Layer 2: n_in=N_H1, n_out=N_H2
  - Output: n_in=N_H2, n_out=N_OUT
- Addressing:
  - `w_addr` = wbase + j·n_in + i, with wbase = 0, N_IN·N_H1, N_IN·N_H1+N_H1·N_H2.
  - `b_addr` = bbase + j, with bbase = 0, N_H1, N_H1+N_H2.
  - `x_addr` = i in layer 1, else 0.
- Input source:
  - Layer 1: `x_data`.
  - Layer 2: internal h1[i]; output layer: internal h2[i].
  - Internal reads are registered, giving the same 1-cycle latency as the external ports.
- Arithmetic:
  - Product: DW×DW signed, sign-extended to ACC_W.
  - First operand of a neuron: acc = `b_data` + p. Later operands: acc = acc + p.
  - The accumulator wraps modulo 2^ACC_W, with no overflow detection.
- Finish, on the last operand of a neuron:
  - s = (acc+p) >>> FRAC.
  - If `hidden`: s<0 → 0.
  - Saturate s to [−2^(DW−1), 2^(DW−1)−1].
  - Register into `y_data`/`y_idx`=j with `y_valid`=1.
  - Layer 1 writes h1[j]; layer 2 writes h2[j]; the output layer writes only the port.

## Timing
- E0 = edge accepting start. Operands for k = j·n_in+i are addressed during the cycle after E0+k, and consumed at E0+k+2.
- Neuron j: `y_valid` high during the cycle after edge E0+(j+1)·n_in+1.
- `calculation_done`: high for exactly the cycle after E0+n_out·n_in+1, coincident with the last `y_valid`.
- `busy` follows the state (RUN/DRAIN/DONE); it is not pulsed.
- Earliest next start is the edge after DONE, i.e. the controller's next layer state.
- Reset (any time, including mid-RUN):
  - State → IDLE; h1, h2, acc cleared.
  - `busy`, `y_valid`, `calculation_done` = 0.
  - `y_idx`, `y_data`, `x_addr`, `w_addr`, `b_addr` = 0.
  - No done pulse for the aborted layer.

## Test plan
- Reset: assert `rst` mid-RUN of layer 1 → all outputs 0 next sample, IDLE, no `calculation_done`; a fresh start then produces full, correct results.
- Layer 1 (`state`=00, `hidden`=1), all x=16, w=16, bias=0 → eight `y_valid` pulses with y_data=64, y_idx 0..7; `calculation_done` one cycle, 129 edges after E0.
- Saturation/ReLU: layer 1 with w=127, x=127, bias 0 → y_data=127. Same layer with bias=−300000 → y_data=0.
- Output layer (`state`=10, `hidden`=0), negative sum −20000 → y_data=−128; y_idx 0..3; done 33 edges after E0.
- Controller handshake: `start_neuron` held high with `state` 00→01→10, each advanced one cycle after `calculation_done` → exactly three done pulses and no retrigger; layer 2 reads the h1 values written in layer 1.
- `state`=11 with `start_neuron`=1 for 10 cycles → stays IDLE, `busy`=0, no pulses.
